// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths, state and FIFO entry types for the MAC accumulator
package mac_pkg;

  localparam int MAC_RES_W = 19;
  localparam int MAC_OUT_W = 8;
  // Widest accumulator a FIFO entry can carry; narrower ACC_W values are sign-extended into it
  localparam int MAC_ACC_W = 32;

  typedef enum logic {
    IDLE,
    ACCUM
  } acc_state_e;

  typedef struct packed {
    logic signed [MAC_OUT_W-1:0] data;
    logic signed [MAC_ACC_W-1:0] acc;
  } fifo_entry_t;

endpackage

// File: rtl/mac_accumulator_if.sv
// rtl/mac_accumulator_if.sv - beat input bus and result stream of the MAC accumulator
interface mac_accumulator_if
  import mac_pkg::*;
#(
  parameter int IN_W  = MAC_RES_W,
  parameter int ACC_W = 32,
  parameter int OUT_W = MAC_OUT_W
);

  logic                    i_valid;
  logic signed [IN_W-1:0]  i_res;
  logic                    i_first;
  logic                    i_last;
  logic [4:0]              i_shift;
  logic                    o_valid;
  logic                    i_ready;
  logic signed [OUT_W-1:0] o_data;
  logic signed [ACC_W-1:0] o_acc;

  modport master (
    output i_valid, i_res, i_first, i_last, i_shift, i_ready,
    input  o_valid, o_data, o_acc
  );

  modport slave (
    input  i_valid, i_res, i_first, i_last, i_shift, i_ready,
    output o_valid, o_data, o_acc
  );

endinterface

// File: rtl/mac_requant.sv
// rtl/mac_requant.sv - rounding arithmetic right shift and saturation to OUT_W bits
module mac_requant
  import mac_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_W = MAC_OUT_W
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic [4:0]              shift,
  output logic signed [OUT_W-1:0] q
);

  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shr;

  // One guard bit keeps the half-LSB rounding add from wrapping at the positive extreme
  always_comb begin
    ext = {acc[ACC_W-1], acc};
    rnd = (shift != 5'd0) ? ((ACC_W+1)'(1) <<< (shift - 5'd1)) : '0;
    sum = ext + rnd;
    shr = sum >>> shift;
    if (shr > SAT_MAX) begin
      q = SAT_MAX[OUT_W-1:0];
    end else if (shr < SAT_MIN) begin
      q = SAT_MIN[OUT_W-1:0];
    end else begin
      q = shr[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - accumulates MAC partial sums, requantizes on the last beat, buffers results
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int IN_W  = MAC_RES_W,
  parameter int ACC_W = 32,
  parameter int OUT_W = MAC_OUT_W,
  parameter int DEPTH = 2
) (
  input  logic                i_clk,
  input  logic                i_nrst,
  mac_accumulator_if.slave    bus,
  input  logic                i_clr_err,
  output logic                o_acc_ovf,
  output logic                o_drop,
  output logic                o_seq_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  acc_state_e              state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] res_ext;
  logic signed [ACC_W-1:0] acc_next;
  logic                    start;
  logic                    ovf_ev;
  logic                    seq_ev;
  logic signed [OUT_W-1:0] rq;

  fifo_entry_t             mem [DEPTH];
  fifo_entry_t             new_entry;
  fifo_entry_t             last_q;
  fifo_entry_t             head;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic                    push_req;
  logic                    pop;
  logic                    push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    res_ext  = ACC_W'(bus.i_res);
    start    = bus.i_first || (state == IDLE);
    acc_next = start ? res_ext : acc + res_ext;
    ovf_ev   = bus.i_valid && !start && (acc[ACC_W-1] == res_ext[ACC_W-1])
               && (acc_next[ACC_W-1] != acc[ACC_W-1]);
    seq_ev   = bus.i_valid && (bus.i_first ? (state == ACCUM) : (state == IDLE));
    push_req = bus.i_valid && bus.i_last;
    pop      = (count != '0) && bus.i_ready;
    // A full FIFO still takes the new result when its head leaves on the same edge
    push     = push_req && ((count < CW'(DEPTH)) || pop);
    new_entry.data = MAC_OUT_W'(rq);
    new_entry.acc  = MAC_ACC_W'(acc_next);
  end

  mac_requant #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_requant (
    .acc   (acc_next),
    .shift (bus.i_shift),
    .q     (rq)
  );

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state     <= IDLE;
      acc       <= '0;
      o_acc_ovf <= 1'b0;
      o_drop    <= 1'b0;
      o_seq_err <= 1'b0;
    end else begin
      if (bus.i_valid) begin
        state <= bus.i_last ? IDLE : ACCUM;
        acc   <= acc_next;
      end
      o_acc_ovf <= ovf_ev || (o_acc_ovf && !i_clr_err);
      o_drop    <= (push_req && !push) || (o_drop && !i_clr_err);
      o_seq_err <= seq_ev || (o_seq_err && !i_clr_err);
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        last_q <= mem[rd_ptr];
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // With the FIFO empty the outputs keep showing the most recently popped entry
  always_comb begin
    head        = (count != '0) ? mem[rd_ptr] : last_q;
    bus.o_valid = (count != '0);
    bus.o_data  = head.data[OUT_W-1:0];
    bus.o_acc   = head.acc[ACC_W-1:0];
  end

endmodule
